// File: rtl/mod_up_counter_if.sv
// Control/status bundle for mod_up_counter; master drives controls, slave is the counter.
interface mod_up_counter_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             En;
  logic             Load;
  logic [WIDTH-1:0] D;
  logic             Clr_ovf;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             Wrap;
  logic             Ovf;

  modport master (
    output En, Load, D, Clr_ovf,
    input  Q, TC, Wrap, Ovf
  );

  modport slave (
    input  En, Load, D, Clr_ovf,
    output Q, TC, Wrap, Ovf
  );
endinterface

// File: rtl/mod_up_counter.sv
// Synchronous modulo-MODULUS up counter with enable, clamped load, cascade TC,
// registered wrap pulse and sticky overflow.
module mod_up_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic           CLK,
  input  logic           Reset,
  mod_up_counter_if.slave bus
);

  localparam logic [WIDTH:0]   ModW = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] QMax = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   inc;
  logic [WIDTH:0]   d_ext;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    // Extra bit keeps the MODULUS == 2^WIDTH rollover visible to the compare.
    inc    = {1'b0, q_q} + 1'b1;
    d_ext  = {1'b0, bus.D};

    if (bus.Clr_ovf) begin
      ovf_d = 1'b0;
    end

    if (bus.Load) begin
      q_d = (d_ext < ModW) ? bus.D : QMax;
    end else if (bus.En) begin
      if (inc >= ModW) begin
        q_d    = '0;
        wrap_d = 1'b1;
        ovf_d  = 1'b1;
      end else begin
        q_d = inc[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.Wrap = wrap_q;
  assign bus.Ovf  = ovf_q;
  assign bus.TC   = (q_q == QMax) && bus.En;

endmodule

// File: tb/tb_mod_up_counter.sv
// Self-checking bench: three counters (MODULUS 10, 16, 2) share one stimulus stream and a
// behavioural model; directed scenarios plus randomized traffic.
module tb_mod_up_counter;

  logic       clk = 1'b0;
  logic       rst, en, load, clr;
  logic [3:0] d;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mod_up_counter_if #(.WIDTH(4)) if_a ();
  mod_up_counter_if #(.WIDTH(4)) if_b ();
  mod_up_counter_if #(.WIDTH(4)) if_c ();

  assign if_a.En = en;  assign if_a.Load = load;  assign if_a.D = d;  assign if_a.Clr_ovf = clr;
  assign if_b.En = en;  assign if_b.Load = load;  assign if_b.D = d;  assign if_b.Clr_ovf = clr;
  assign if_c.En = en;  assign if_c.Load = load;  assign if_c.D = d;  assign if_c.Clr_ovf = clr;

  mod_up_counter #(.WIDTH(4), .MODULUS(10)) u_a (.CLK(clk), .Reset(rst), .bus(if_a));
  mod_up_counter #(.WIDTH(4), .MODULUS(16)) u_b (.CLK(clk), .Reset(rst), .bus(if_b));
  mod_up_counter #(.WIDTH(4), .MODULUS(2))  u_c (.CLK(clk), .Reset(rst), .bus(if_c));

  logic [3:0] q_o[3];
  logic       tc_o[3], wrap_o[3], ovf_o[3];

  always_comb begin
    q_o[0] = if_a.Q;  tc_o[0] = if_a.TC;  wrap_o[0] = if_a.Wrap;  ovf_o[0] = if_a.Ovf;
    q_o[1] = if_b.Q;  tc_o[1] = if_b.TC;  wrap_o[1] = if_b.Wrap;  ovf_o[1] = if_b.Ovf;
    q_o[2] = if_c.Q;  tc_o[2] = if_c.TC;  wrap_o[2] = if_c.Wrap;  ovf_o[2] = if_c.Ovf;
  end

  // Behavioural model: count kept as an integer, advanced with modular arithmetic.
  int mods[3] = '{10, 16, 2};
  int mq[3];
  int mw[3];
  int mo[3];

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mq[i] = 0; mw[i] = 0; mo[i] = 0;
      end else begin
        mw[i] = 0;
        if (clr) mo[i] = 0;
        if (load) begin
          mq[i] = (int'(d) < mods[i]) ? int'(d) : mods[i] - 1;
        end else if (en) begin
          mq[i] = (mq[i] + 1) % mods[i];
          if (mq[i] == 0) begin
            mw[i] = 1; mo[i] = 1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; clr = 1'b0; d = 4'd0;
    step();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (q_o[i] !== 4'd0 || wrap_o[i] !== 1'b0 || ovf_o[i] !== 1'b0 || tc_o[i] !== 1'b0) begin
        n_err++;
        $display("FAIL reset dut%0d: got q=%0d wrap=%b ovf=%b tc=%b, want 0/0/0/0",
                 i, q_o[i], wrap_o[i], ovf_o[i], tc_o[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_count();
    rst = 1'b1; step(); rst = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (tc_o[0] !== (k == 9)) begin
        n_err++;
        $display("FAIL count_tc edge%0d: got %b, want %b", k, tc_o[0], (k == 9));
      end
      step();
      n_cmp++;
      if (q_o[0] !== 4'((k + 1) % 10) || wrap_o[0] !== (k == 9) || ovf_o[0] !== (k >= 9)) begin
        n_err++;
        $display("FAIL count edge%0d: got q=%0d wrap=%b ovf=%b, want q=%0d wrap=%b ovf=%b",
                 k, q_o[0], wrap_o[0], ovf_o[0], (k + 1) % 10, (k == 9), (k >= 9));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load();
    logic [3:0] dv[3] = '{4'd7, 4'd13, 4'd3};
    logic [3:0] qv[3] = '{4'd7, 4'd9, 4'd3};
    load = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d  = dv[k];
      en = (k == 2);
      step();
      n_cmp++;
      if (q_o[0] !== qv[k] || wrap_o[0] !== 1'b0 || ovf_o[0] !== 1'b1) begin
        n_err++;
        $display("FAIL load d=%0d: got q=%0d wrap=%b ovf=%b, want q=%0d wrap=0 ovf=1",
                 dv[k], q_o[0], wrap_o[0], ovf_o[0], qv[k]);
      end
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_hold();
    load = 1'b1; d = 4'd5; step(); load = 1'b0; en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if (q_o[0] !== 4'd5 || tc_o[0] !== 1'b0 || wrap_o[0] !== 1'b0) begin
        n_err++;
        $display("FAIL hold edge%0d: got q=%0d tc=%b wrap=%b, want q=5 tc=0 wrap=0",
                 k, q_o[0], tc_o[0], wrap_o[0]);
      end
    end
    load = 1'b1; d = 4'd9; step(); load = 1'b0;
    #1;
    n_cmp++;
    if (tc_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL tc_en_low: got %b, want 0", tc_o[0]);
    end
    en = 1'b1;
    #1;
    n_cmp++;
    if (tc_o[0] !== 1'b1 || q_o[0] !== 4'd9) begin
      n_err++;
      $display("FAIL tc_en_high: got tc=%b q=%0d, want tc=1 q=9", tc_o[0], q_o[0]);
    end
    en = 1'b0;
  endtask

  task automatic test_ovf_clear();
    clr = 1'b1;
    step();
    n_cmp++;
    if (ovf_o[0] !== 1'b0 || q_o[0] !== 4'd9) begin
      n_err++;
      $display("FAIL ovf_clear: got ovf=%b q=%0d, want ovf=0 q=9", ovf_o[0], q_o[0]);
    end
    en = 1'b1;
    step();
    n_cmp++;
    if (q_o[0] !== 4'd0 || ovf_o[0] !== 1'b1 || wrap_o[0] !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_collision: got q=%0d ovf=%b wrap=%b, want q=0 ovf=1 wrap=1",
               q_o[0], ovf_o[0], wrap_o[0]);
    end
    clr = 1'b0; en = 1'b0;
    step();
    n_cmp++;
    if (wrap_o[0] !== 1'b0 || ovf_o[0] !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_pulse_end: got wrap=%b ovf=%b, want wrap=0 ovf=1", wrap_o[0], ovf_o[0]);
    end
  endtask

  task automatic test_reset_mid();
    load = 1'b1; d = 4'd6; step(); load = 1'b0;
    en = 1'b1;
    rst = 1'b1; load = 1'b1; d = 4'd4;
    #2;
    n_cmp++;
    if (q_o[0] !== 4'd6) begin
      n_err++;
      $display("FAIL reset_between_edges: got q=%0d, want 6", q_o[0]);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if (q_o[0] !== 4'd0 || wrap_o[0] !== 1'b0 || ovf_o[0] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid edge%0d: got q=%0d wrap=%b ovf=%b, want 0/0/0",
                 k, q_o[0], wrap_o[0], ovf_o[0]);
      end
    end
    rst = 1'b0; load = 1'b0;
    step();
    n_cmp++;
    if (q_o[0] !== 4'd1) begin
      n_err++;
      $display("FAIL reset_release: got q=%0d, want 1", q_o[0]);
    end
    en = 1'b0;
  endtask

  task automatic test_full_range();
    rst = 1'b1; step(); rst = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      n_cmp++;
      if (tc_o[1] !== (k == 15) || tc_o[2] !== (k % 2 == 1)) begin
        n_err++;
        $display("FAIL range_tc edge%0d: got tc16=%b tc2=%b, want %b %b",
                 k, tc_o[1], tc_o[2], (k == 15), (k % 2 == 1));
      end
      step();
      n_cmp++;
      if (q_o[1] !== 4'((k + 1) % 16) || wrap_o[1] !== (k == 15)) begin
        n_err++;
        $display("FAIL range16 edge%0d: got q=%0d wrap=%b, want q=%0d wrap=%b",
                 k, q_o[1], wrap_o[1], (k + 1) % 16, (k == 15));
      end
      n_cmp++;
      if (q_o[2] !== 4'((k + 1) % 2) || wrap_o[2] !== (k % 2 == 1)) begin
        n_err++;
        $display("FAIL mod2 edge%0d: got q=%0d wrap=%b, want q=%0d wrap=%b",
                 k, q_o[2], wrap_o[2], (k + 1) % 2, (k % 2 == 1));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst  = ($urandom_range(0, 31) == 0);
      load = ($urandom_range(0, 7) == 0);
      en   = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 9) == 0);
      d    = 4'($urandom);
      #1;
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (tc_o[i] !== ((mq[i] == mods[i] - 1) && en)) begin
          n_err++;
          $display("FAIL rand_tc dut%0d cyc%0d: got %b, want %b",
                   i, k, tc_o[i], ((mq[i] == mods[i] - 1) && en));
        end
      end
      step();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (q_o[i] !== 4'(mq[i]) || wrap_o[i] !== mw[i][0] || ovf_o[i] !== mo[i][0]) begin
          n_err++;
          $display("FAIL rand dut%0d cyc%0d: got q=%0d wrap=%b ovf=%b, want q=%0d wrap=%0d ovf=%0d",
                   i, k, q_o[i], wrap_o[i], ovf_o[i], mq[i], mw[i], mo[i]);
        end
      end
    end
    rst = 1'b0; load = 1'b0; en = 1'b0; clr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; clr = 1'b0; d = 4'd0;
    #1;
    test_reset();
    test_count();
    test_load();
    test_hold();
    test_ovf_clear();
    test_reset_mid();
    test_full_range();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
